// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the DAC serial-link receiver.
package spi_rx_pkg;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  localparam int DEFAULT_WORD_BITS = 16;
  localparam int DEFAULT_TIMEOUT   = 4096;

endpackage

// File: rtl/spi_rx_input_sync.sv
// Multi-flop synchronizer for one link input plus a single delay flop,
// so the core can see both the current and the previous synchronized level.
module spi_rx_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q_s,
  output logic q_s_d
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // next values: shift the raw input in, delay flop follows the last stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // synchronizer chain and delay flop, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign q_s   = sync_q[SYNC_STAGES-1];
  assign q_s_d = dly_q;

endmodule

// File: rtl/spi_dac_frame_receiver.sv
// Receiver for the 3-wire DAC link: oversamples sclk/sync/mosi with clk,
// deserializes MSB-first words and flags aborted frames.
//
//   state | meaning
//   IDLE  | waiting for an sclk rising edge that carries sync=1
//   SHIFT | frame in progress, collecting WORD_BITS data bits
module spi_dac_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int WORD_BITS      = DEFAULT_WORD_BITS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 sync,
  input  logic                 mosi,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic sclk_s, sclk_s_d, sync_s, sync_s_d, mosi_s, mosi_s_d;
  logic bit_event;

  spi_rx_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q_s(sclk_s), .q_s_d(sclk_s_d));
  spi_rx_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(clk), .rst_n(rst_n), .d(sync), .q_s(sync_s), .q_s_d(sync_s_d));
  spi_rx_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q_s(mosi_s), .q_s_d(mosi_s_d));

  // Only the pre-edge (delayed) copies of sync and mosi are sampled.
  logic unused_inputs;
  assign unused_inputs = sync_s ^ mosi_s;

  assign bit_event = sclk_s & ~sclk_s_d;

  rx_state_t            state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [WORD_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [WORD_BITS-1:0] shifted;

  // frame FSM: next state, shift register, counters and output pulses
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    frame_count_d = frame_count_q;
    shifted       = {shift_q[WORD_BITS-2:0], mosi_s_d};

    case (state_q)
      IDLE: begin
        // idle clocks with sync low are normal transmitter filler
        if (bit_event && sync_s_d) begin
          state_d   = SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      SHIFT: begin
        if (bit_event) begin
          tmo_d = '0;
          if (sync_s_d) begin
            // early restart: this edge opens a new frame and carries no data
            frame_error_d = 1'b1;
            shift_d       = '0;
            bit_cnt_d     = '0;
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              data_out_d    = shifted;
              data_valid_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = IDLE;
            end
          end
        end else if (tmo_q >= TMO_LIMIT - 1'b1) begin
          tmo_d         = TMO_LIMIT;
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == SHIFT);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Bench for spi_dac_frame_receiver: directed scenarios plus random frames,
// with a frame-level reference model compared against the DUT every cycle.
module tb_spi_dac_frame_receiver;

  localparam int W = 16;
  localparam int S = 2;
  localparam int T = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        sync = 1'b0;
  logic        mosi = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  spi_dac_frame_receiver #(.WORD_BITS(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sync(sync), .mosi(mosi),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
    .busy(busy), .frame_count(frame_count));

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;
  int n_dv = 0, n_fe = 0, n_busy = 0;
  logic [15:0] dv_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input history (index 0 = most recent clk sample). The link is
  // seen SYNC_STAGES samples late; a bit is taken when the late sclk
  // level goes 0->1, using the sync/mosi level from the sample before it.
  int h_sclk[0:S];
  int h_sync[0:S];
  int h_mosi[0:S];
  bit m_in = 0;
  int m_nbits = 0, m_word = 0, m_idle = 0, m_dout = 0, m_fcnt = 0;
  bit m_dv = 0, m_fe = 0;

  always @(posedge clk or negedge rst_n) begin
    bit ev, sy, mo;
    if (!rst_n) begin
      for (int i = 0; i <= S; i++) begin h_sclk[i] = 0; h_sync[i] = 0; h_mosi[i] = 0; end
      m_in = 0; m_nbits = 0; m_word = 0; m_idle = 0; m_dout = 0; m_fcnt = 0;
      m_dv = 0; m_fe = 0;
    end else begin
      ev = (h_sclk[S-1] == 1) && (h_sclk[S] == 0);
      sy = h_sync[S][0];
      mo = h_mosi[S][0];
      m_dv = 0;
      m_fe = 0;
      if (ev && !m_in) begin
        if (sy) begin m_in = 1; m_nbits = 0; m_word = 0; m_idle = 0; end
      end else if (ev && m_in) begin
        m_idle = 0;
        if (sy) begin
          m_fe = 1; m_nbits = 0; m_word = 0;
        end else begin
          m_word = ((m_word << 1) | int'(mo)) & 32'hFFFF;
          m_nbits++;
          if (m_nbits == W) begin
            m_dout = m_word; m_dv = 1; m_fcnt = (m_fcnt + 1) & 32'hFFFF; m_in = 0;
          end
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle == T) begin m_fe = 1; m_in = 0; end
      end
      for (int i = S; i > 0; i--) begin
        h_sclk[i] = h_sclk[i-1]; h_sync[i] = h_sync[i-1]; h_mosi[i] = h_mosi[i-1];
      end
      h_sclk[0] = int'(sclk); h_sync[0] = int'(sync); h_mosi[0] = int'(mosi);
    end
  end

  // per-cycle compare against the model, plus pulse bookkeeping
  always @(negedge clk) begin
    logic [35:0] act, exp;
    act = {data_out, data_valid, frame_error, busy, frame_count};
    exp = {m_dout[15:0], m_dv, m_fe, m_in, m_fcnt[15:0]};
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle_compare t=%0t (actual/required) dout=%h/%h dv=%b/%b fe=%b/%b busy=%b/%b fc=%h/%h",
                 $time, data_out, m_dout[15:0], data_valid, m_dv, frame_error, m_fe,
                 busy, m_in, frame_count, m_fcnt[15:0]);
      end
    end
    if (data_valid && frame_error) begin
      checks++; errors++;
      $display("FAIL dv_fe_exclusive t=%0t actual=both_high required=not_both", $time);
    end
    if (data_valid) begin n_dv++; dv_words.push_back(data_out); end
    if (frame_error) n_fe++;
    if (busy) n_busy++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync_point();
    @(negedge clk); #1;
  endtask

  task automatic send_bit(input logic s, input logic m, input int lo, input int hi);
    sclk = 1'b0; sync = s; mosi = m;
    repeat (lo) @(negedge clk);
    sclk = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] w, input int lo, input int hi);
    send_bit(1'b1, 1'b0, lo, hi);
    for (int i = W - 1; i >= 0; i--) send_bit(1'b0, w[i], lo, hi);
  endtask

  task automatic settle();
    sclk = 1'b0; sync = 1'b0;
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; sclk = 1'b0; sync = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    sync_point();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int d0, f0, b0, cnt, n_abort, k, lo, hi;
    logic [15:0] w, last_w;

    do_reset();
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_frame_count", 32'(frame_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // single frame 0xA5C3 with latency pin on the final bit
    w = 16'hA5C3; d0 = n_dv; f0 = n_fe;
    send_bit(1'b1, 1'b0, 2, 2);
    for (int i = W - 1; i >= 1; i--) send_bit(1'b0, w[i], 2, 2);
    sclk = 1'b0; sync = 1'b0; mosi = w[0];
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("latency_not_yet", 32'(data_valid), 32'h0);
    @(posedge clk); #1;
    check("latency_pulse", 32'(data_valid), 32'h1);
    check("single_data_out", 32'(data_out), 32'hA5C3);
    @(negedge clk);
    settle();
    check("single_dv_count", 32'(n_dv - d0), 32'd1);
    check("single_fe_count", 32'(n_fe - f0), 32'd0);
    check("single_frame_count", 32'(frame_count), 32'd1);

    // back-to-back frames
    do_reset();
    d0 = n_dv;
    send_frame(16'h0001, 2, 2);
    send_frame(16'hFFFF, 2, 2);
    settle();
    check("b2b_dv_count", 32'(n_dv - d0), 32'd2);
    check("b2b_first_word", 32'(dv_words[dv_words.size()-2]), 32'h0001);
    check("b2b_second_word", 32'(dv_words[dv_words.size()-1]), 32'hFFFF);
    check("b2b_frame_count", 32'(frame_count), 32'd2);

    // early restart after 7 data bits
    do_reset();
    d0 = n_dv; f0 = n_fe;
    send_bit(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'($urandom_range(1, 0)), 2, 2);
    send_frame(16'h1234, 2, 2);
    settle();
    check("restart_fe_count", 32'(n_fe - f0), 32'd1);
    check("restart_dv_count", 32'(n_dv - d0), 32'd1);
    check("restart_data_out", 32'(data_out), 32'h1234);
    check("restart_frame_count", 32'(frame_count), 32'd1);

    // timeout after sync + 5 bits
    f0 = n_fe;
    send_bit(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'(i), 2, 2);
    sclk = 1'b0;
    cnt = 0;
    while (cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
      if (frame_error) break;
    end
    check("timeout_cycles", 32'(cnt), 32'd4097);
    check("timeout_busy_low", 32'(busy), 32'h0);
    check("timeout_data_kept", 32'(data_out), 32'h1234);
    settle();
    check("timeout_fe_count", 32'(n_fe - f0), 32'd1);

    // idle clocks with sync low
    d0 = n_dv; f0 = n_fe; b0 = n_busy;
    for (int i = 0; i < 40; i++)
      send_bit(1'b0, 1'(i), $urandom_range(2, 1), $urandom_range(2, 1));
    settle();
    check("idle_dv_count", 32'(n_dv - d0), 32'd0);
    check("idle_fe_count", 32'(n_fe - f0), 32'd0);
    check("idle_busy_cycles", 32'(n_busy - b0), 32'd0);

    // reset mid-frame, then a clean 0xBEEF frame
    d0 = n_dv; f0 = n_fe;
    send_bit(1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(1, 0)), 2, 2);
    sync_point();
    check("midframe_busy", 32'(busy), 32'h1);
    @(posedge clk); #2 rst_n = 1'b0; sclk = 1'b0; sync = 1'b0;
    #1;
    check("rst_outputs_zero", {data_out, data_valid, frame_error, busy, 13'd0},
          32'h0);
    check("rst_frame_count_zero", 32'(frame_count), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sync_point();
    send_frame(16'hBEEF, 2, 2);
    settle();
    check("after_rst_data_out", 32'(data_out), 32'hBEEF);
    check("after_rst_frame_count", 32'(frame_count), 32'd1);
    check("after_rst_dv_count", 32'(n_dv - d0), 32'd1);
    check("after_rst_fe_count", 32'(n_fe - f0), 32'd0);

    // random frames with random sclk timing, aborts and idle filler
    do_reset();
    d0 = n_dv; f0 = n_fe; n_abort = 0; last_w = '0;
    for (int f = 0; f < 30; f++) begin
      lo = $urandom_range(3, 1);
      hi = $urandom_range(3, 1);
      w = 16'($urandom);
      if ($urandom_range(4, 0) == 0) begin
        k = $urandom_range(15, 0);
        send_bit(1'b1, 1'b0, lo, hi);
        for (int i = 0; i < k; i++) send_bit(1'b0, 1'($urandom_range(1, 0)), lo, hi);
        n_abort++;
      end
      send_frame(w, lo, hi);
      last_w = w;
      k = $urandom_range(3, 0);
      for (int i = 0; i < k; i++)
        send_bit(1'b0, 1'($urandom_range(1, 0)), $urandom_range(3, 1), $urandom_range(3, 1));
    end
    settle();
    check("rand_frame_count", 32'(frame_count), 32'd30);
    check("rand_dv_count", 32'(n_dv - d0), 32'd30);
    check("rand_fe_count", 32'(n_fe - f0), 32'(n_abort));
    check("rand_last_word", 32'(data_out), 32'(last_w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
